// File: rtl/cnn_layer_accel_quad_lite.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cnn_layer_accel_quad_lite                                        |
// | Brief   : Single-quad 3x3 conv engine (4 channels, stride/pad/upsample).   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module cnn_layer_accel_quad_lite #(
    parameter int MAX_NUM_INPUT_COLS = 32,
    parameter int MAX_KERNELS        = 16,
    parameter int NUM_CE_PER_QUAD    = 4
) (
    input  logic         clk_core,
    input  logic         rst,
    input  logic         job_start,
    output logic         job_accept,
    input  logic [127:0] job_parameters,
    output logic         job_complete,
    input  logic         job_complete_ack,
    input  logic         weight_valid,
    output logic         weight_ready,
    input  logic [127:0] weight_data,
    input  logic         pixel_valid,
    output logic         pixel_ready,
    input  logic [127:0] pixel_data,
    output logic         result_valid,
    input  logic         result_accept,
    output logic [15:0]  result_data
);

    localparam int c_PDEPTH  = MAX_NUM_INPUT_COLS * MAX_NUM_INPUT_COLS;
    localparam int c_PADDR_W = $clog2(c_PDEPTH);
    localparam int c_WDEPTH  = MAX_KERNELS * 9;
    localparam int c_WADDR_W = $clog2(c_WDEPTH);
    localparam int c_CH_W    = $clog2(NUM_CE_PER_QUAD);
    localparam int c_WORD_W  = 16 * NUM_CE_PER_QUAD;
    localparam int c_MACS    = 9 * NUM_CE_PER_QUAD;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD_W  = 3'd1;
    localparam logic [2:0] c_LOAD_P  = 3'd2;
    localparam logic [2:0] c_COMPUTE = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0] r_state, w_next;
    logic       r_job_accept, r_weight_ready, r_pixel_ready, r_job_complete;

    logic [5:0] r_rows, r_cols;
    logic [4:0] r_nk;
    logic       r_stride, r_pad, r_up;

    logic [c_WADDR_W-1:0] r_widx;
    logic [5:0]           r_prow, r_pcol;

    logic [c_WORD_W-1:0] r_wmem [c_WDEPTH];
    logic [c_WORD_W-1:0] r_pmem [c_PDEPTH];

    logic [5:0]           r_orow, r_ocol;
    logic [4:0]           r_k;
    logic [c_WADDR_W-1:0] r_wbase;
    logic [1:0]           r_ky, r_kx;
    logic [c_CH_W-1:0]    r_ch;
    logic [5:0]           r_mac_cnt;
    logic                 r_mac_busy;
    logic [39:0]          r_acc;
    logic                 r_result_valid;
    logic [15:0]          r_result_data;

    function automatic logic [c_PADDR_W-1:0] paddr(input logic [5:0] row, input logic [5:0] col);
        return c_PADDR_W'(row) * c_PADDR_W'(MAX_NUM_INPUT_COLS) + c_PADDR_W'(col);
    endfunction

    // Load handshakes and phase ends
    logic                 w_wbeat, w_pbeat, w_wlast, w_plast;
    logic [c_WADDR_W:0]   w_wtotal;
    assign w_wbeat  = (r_state == c_LOAD_W) && weight_valid && r_weight_ready;
    assign w_pbeat  = (r_state == c_LOAD_P) && pixel_valid && r_pixel_ready;
    assign w_wtotal = (c_WADDR_W+1)'(r_nk) * (c_WADDR_W+1)'(9);
    assign w_wlast  = ({1'b0, r_widx} == w_wtotal - 1'b1);
    assign w_plast  = (r_prow == r_rows - 6'd1) && (r_pcol == r_cols - 6'd1);

    // Expanded and padded geometry; w_*_m1 is the last output index
    logic [6:0] w_re, w_ce;
    logic [7:0] w_span_r, w_span_c, w_ro_m1, w_co_m1;
    logic       w_has_out;
    assign w_re      = r_up ? {r_rows, 1'b0} : {1'b0, r_rows};
    assign w_ce      = r_up ? {r_cols, 1'b0} : {1'b0, r_cols};
    assign w_span_r  = {1'b0, w_re} + {6'd0, r_pad, 1'b0};
    assign w_span_c  = {1'b0, w_ce} + {6'd0, r_pad, 1'b0};
    assign w_has_out = (w_span_r >= 8'd3) && (w_span_c >= 8'd3);
    assign w_ro_m1   = (w_span_r - 8'd3) >> r_stride;
    assign w_co_m1   = (w_span_c - 8'd3) >> r_stride;

    logic w_k_last, w_col_last, w_row_last, w_out_last;
    assign w_k_last   = (r_k == r_nk - 5'd1);
    assign w_col_last = ({2'b0, r_ocol} == w_co_m1);
    assign w_row_last = ({2'b0, r_orow} == w_ro_m1);
    assign w_out_last = w_k_last && w_col_last && w_row_last;

    // Tap coordinate in expanded space; bit 8 set means above/left of the image
    logic [7:0] w_ys, w_xs;
    logic [8:0] w_y, w_x;
    logic       w_in_img;
    logic [5:0] w_sy, w_sx;
    assign w_ys     = {2'b0, r_orow} << r_stride;
    assign w_xs     = {2'b0, r_ocol} << r_stride;
    assign w_y      = {1'b0, w_ys} + {7'd0, r_ky} - {8'd0, r_pad};
    assign w_x      = {1'b0, w_xs} + {7'd0, r_kx} - {8'd0, r_pad};
    assign w_in_img = !w_y[8] && !w_x[8] && (w_y[7:0] < {1'b0, w_re}) && (w_x[7:0] < {1'b0, w_ce});
    assign w_sy     = 6'(w_y[7:0] >> r_up);
    assign w_sx     = 6'(w_x[7:0] >> r_up);

    logic [c_WADDR_W-1:0] w_waddr;
    logic [c_WORD_W-1:0]  w_wword, w_pword;
    logic signed [15:0]   w_wt, w_px;
    logic signed [31:0]   w_prod;
    logic [39:0]          w_acc_next;
    logic                 w_mac_last;
    assign w_waddr    = r_wbase + c_WADDR_W'({r_ky, 1'b0}) + c_WADDR_W'(r_ky) + c_WADDR_W'(r_kx);
    assign w_wword    = r_wmem[w_waddr];
    assign w_pword    = r_pmem[paddr(w_sy, w_sx)];
    assign w_wt       = w_wword[{r_ch, 4'b0000} +: 16];
    assign w_px       = w_in_img ? w_pword[{r_ch, 4'b0000} +: 16] : 16'sd0;
    assign w_prod     = w_wt * w_px;
    assign w_acc_next = r_acc + {{8{w_prod[31]}}, w_prod};
    assign w_mac_last = (r_mac_cnt == 6'(c_MACS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:    if (job_start && r_job_accept)
                           w_next = (job_parameters[16:12] == 5'd0) ? c_DONE : c_LOAD_W;
            c_LOAD_W:  if (w_wbeat && w_wlast) w_next = c_LOAD_P;
            c_LOAD_P:  if (w_pbeat && w_plast) w_next = c_COMPUTE;
            c_COMPUTE: begin
                if (!w_has_out)
                    w_next = c_DONE;
                else if (r_result_valid && result_accept && w_out_last)
                    w_next = c_DONE;
            end
            c_DONE:    if (job_complete_ack) w_next = c_IDLE;
            default:   w_next = c_IDLE;
        endcase
    end

    // Handshake outputs are registered decodes of the next state so they read 0 in reset
    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_job_accept   <= 1'b0;
            r_weight_ready <= 1'b0;
            r_pixel_ready  <= 1'b0;
            r_job_complete <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_job_accept   <= (w_next == c_IDLE);
            r_weight_ready <= (w_next == c_LOAD_W);
            r_pixel_ready  <= (w_next == c_LOAD_P);
            r_job_complete <= (w_next == c_DONE);
        end
    end

    always_ff @(posedge clk_core) begin
        if (w_wbeat) r_wmem[r_widx] <= weight_data[c_WORD_W-1:0];
        if (w_pbeat) r_pmem[paddr(r_prow, r_pcol)] <= pixel_data[c_WORD_W-1:0];
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_rows <= '0; r_cols <= '0; r_nk <= '0;
            r_stride <= 1'b0; r_pad <= 1'b0; r_up <= 1'b0;
            r_widx <= '0; r_prow <= '0; r_pcol <= '0;
            r_orow <= '0; r_ocol <= '0; r_k <= '0; r_wbase <= '0;
            r_ky <= '0; r_kx <= '0; r_ch <= '0; r_mac_cnt <= '0;
            r_mac_busy <= 1'b0; r_acc <= '0;
            r_result_valid <= 1'b0; r_result_data <= '0;
        end else begin
            if (r_state == c_IDLE && job_start && r_job_accept) begin
                r_rows   <= job_parameters[5:0];
                r_cols   <= job_parameters[11:6];
                r_nk     <= job_parameters[16:12];
                r_stride <= job_parameters[17];
                r_pad    <= job_parameters[18];
                r_up     <= job_parameters[19];
                r_widx   <= '0;
                r_prow   <= '0;
                r_pcol   <= '0;
            end
            if (w_wbeat) r_widx <= r_widx + 1'b1;
            if (w_pbeat) begin
                if (r_pcol == r_cols - 6'd1) begin
                    r_pcol <= '0;
                    r_prow <= r_prow + 6'd1;
                end else begin
                    r_pcol <= r_pcol + 6'd1;
                end
            end

            if (w_pbeat && w_plast) begin
                r_orow <= '0; r_ocol <= '0; r_k <= '0; r_wbase <= '0;
                r_ky <= '0; r_kx <= '0; r_ch <= '0; r_mac_cnt <= '0;
                r_acc <= '0;
                r_mac_busy <= w_has_out;
            end else if (r_state == c_COMPUTE) begin
                if (r_mac_busy) begin
                    r_acc     <= w_acc_next;
                    r_mac_cnt <= r_mac_cnt + 6'd1;
                    r_ch      <= r_ch + 1'b1;
                    if (r_ch == c_CH_W'(NUM_CE_PER_QUAD - 1)) begin
                        r_ch <= '0;
                        if (r_kx == 2'd2) begin
                            r_kx <= '0;
                            r_ky <= r_ky + 2'd1;
                        end else begin
                            r_kx <= r_kx + 2'd1;
                        end
                    end
                    if (w_mac_last) begin
                        r_mac_busy     <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_result_data  <= w_acc_next[15:0];
                    end
                end else if (r_result_valid && result_accept) begin
                    r_result_valid <= 1'b0;
                    if (!w_out_last) begin
                        // kernel innermost, then column, then row
                        if (w_k_last) begin
                            r_k     <= '0;
                            r_wbase <= '0;
                            if (w_col_last) begin
                                r_ocol <= '0;
                                r_orow <= r_orow + 6'd1;
                            end else begin
                                r_ocol <= r_ocol + 6'd1;
                            end
                        end else begin
                            r_k     <= r_k + 5'd1;
                            r_wbase <= r_wbase + c_WADDR_W'(9);
                        end
                        r_ky <= '0; r_kx <= '0; r_ch <= '0; r_mac_cnt <= '0;
                        r_acc      <= '0;
                        r_mac_busy <= 1'b1;
                    end
                end
            end else begin
                r_mac_busy     <= 1'b0;
                r_result_valid <= 1'b0;
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{job_parameters[127:20], weight_data[127:c_WORD_W], pixel_data[127:c_WORD_W]};

    assign job_accept   = r_job_accept;
    assign weight_ready = r_weight_ready;
    assign pixel_ready  = r_pixel_ready;
    assign job_complete = r_job_complete;
    assign result_valid = r_result_valid;
    assign result_data  = r_result_data;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_quad_lite.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_cnn_layer_accel_quad_lite                                     |
// | Brief   : Randomised scoreboard bench with a loop-level convolution model. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_cnn_layer_accel_quad_lite;

    localparam int c_MAXC = 32;
    localparam int c_MAXK = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_start = 1'b0;
    logic         job_accept;
    logic [127:0] job_parameters = '0;
    logic         job_complete;
    logic         job_complete_ack = 1'b0;
    logic         weight_valid = 1'b0;
    logic         weight_ready;
    logic [127:0] weight_data = '0;
    logic         pixel_valid = 1'b0;
    logic         pixel_ready;
    logic [127:0] pixel_data = '0;
    logic         result_valid;
    logic         result_accept = 1'b0;
    logic [15:0]  result_data;

    always #5 clk = ~clk;

    cnn_layer_accel_quad_lite #(
        .MAX_NUM_INPUT_COLS(c_MAXC),
        .MAX_KERNELS(c_MAXK),
        .NUM_CE_PER_QUAD(4)
    ) dut (
        .clk_core(clk),
        .rst(rst),
        .job_start(job_start),
        .job_accept(job_accept),
        .job_parameters(job_parameters),
        .job_complete(job_complete),
        .job_complete_ack(job_complete_ack),
        .weight_valid(weight_valid),
        .weight_ready(weight_ready),
        .weight_data(weight_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .pixel_data(pixel_data),
        .result_valid(result_valid),
        .result_accept(result_accept),
        .result_data(result_data)
    );

    logic signed [15:0] wts [c_MAXK][9][4];
    logic signed [15:0] pix [c_MAXC][c_MAXC][4];
    logic [15:0]        exp_q [$];
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 stall_req = 0;
    logic               pend = 1'b0;
    logic [15:0]        held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: owns result_accept, compares every accepted result
    always @(negedge clk) begin
        if (rst) begin
            result_accept = 1'b0;
            pend = 1'b0;
        end else if (result_valid) begin
            if (pend) check("result_held_stable", result_data, held);
            if (stall_req > 0) begin
                stall_req--;
                result_accept = 1'b0;
            end else begin
                result_accept = ($urandom_range(3) != 0);
            end
            if (result_accept) begin
                pend = 1'b0;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_result: got %0h, required none", result_data);
                end else begin
                    check("result", result_data, exp_q.pop_front());
                end
            end else begin
                pend = 1'b1;
                held = result_data;
            end
        end else begin
            if (pend) begin
                n_vec++; n_err++;
                $display("FAIL valid_dropped: got 0, required 1");
            end
            pend = 1'b0;
            result_accept = 1'b0;
        end
    end

    // Reference: direct sum over the expanded, padded image
    task automatic model(input int r, input int c, input int k, input int s, input int p, input int u);
        int re, ce, ro, co, y, x;
        longint acc;
        re = r << u;
        ce = c << u;
        if (re + 2*p < 3 || ce + 2*p < 3) return;
        ro = (re + 2*p - 3) / s + 1;
        co = (ce + 2*p - 3) / s + 1;
        for (int orow = 0; orow < ro; orow++)
            for (int ocol = 0; ocol < co; ocol++)
                for (int kk = 0; kk < k; kk++) begin
                    acc = 0;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            for (int ch = 0; ch < 4; ch++) begin
                                y = orow*s + ky - p;
                                x = ocol*s + kx - p;
                                if (y >= 0 && y < re && x >= 0 && x < ce)
                                    acc += longint'(wts[kk][ky*3+kx][ch]) * longint'(pix[y>>u][x>>u][ch]);
                            end
                    exp_q.push_back(acc[15:0]);
                end
    endtask

    function automatic logic [63:0] wbeat(input int idx);
        int kk = idx / 9;
        int t  = idx % 9;
        return {wts[kk][t][3], wts[kk][t][2], wts[kk][t][1], wts[kk][t][0]};
    endfunction

    function automatic logic [63:0] pbeat(input int idx, input int c);
        int rr = idx / c;
        int cc = idx % c;
        return {pix[rr][cc][3], pix[rr][cc][2], pix[rr][cc][1], pix[rr][cc][0]};
    endfunction

    task automatic fill(input int wv, input int pv);
        for (int a = 0; a < c_MAXK; a++) for (int t = 0; t < 9; t++) for (int ch = 0; ch < 4; ch++)
            wts[a][t][ch] = 16'(wv);
        for (int a = 0; a < c_MAXC; a++) for (int b = 0; b < c_MAXC; b++) for (int ch = 0; ch < 4; ch++)
            pix[a][b][ch] = 16'(pv);
    endtask

    task automatic fill_random();
        for (int a = 0; a < c_MAXK; a++) for (int t = 0; t < 9; t++) for (int ch = 0; ch < 4; ch++)
            wts[a][t][ch] = 16'($urandom);
        for (int a = 0; a < c_MAXC; a++) for (int b = 0; b < c_MAXC; b++) for (int ch = 0; ch < 4; ch++)
            pix[a][b][ch] = 16'($urandom);
    endtask

    // abort_at >= 0 asserts rst after that many pixel beats
    task automatic run_job(input int r, input int c, input int k, input int s, input int p,
                           input int u, input int abort_at);
        int idx, wc, pc, guard, budget, cyc;
        logic hs;
        if (abort_at < 0) model(r, c, k, s, p, u);
        guard = 0;
        @(negedge clk);
        while (!job_accept && guard < 50) begin @(negedge clk); guard++; end
        check("job_accept_idle", job_accept, 1);
        job_parameters = {$urandom, $urandom, $urandom, $urandom};
        job_parameters[19:0] = {u[0], p[0], (s == 2), k[4:0], c[5:0], r[5:0]};
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;

        wc = 0; pc = 0; idx = 0; guard = 0;
        while (idx < k*9 && guard < 4000) begin
            weight_valid = ($urandom_range(3) != 0);
            weight_data  = {$urandom, $urandom, wbeat(idx)};
            hs = weight_valid && weight_ready;
            @(negedge clk);
            if (hs) begin idx++; wc++; end
            guard++;
        end
        idx = 0; cyc = 0;
        while (k > 0 && idx < r*c && guard < 8000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            weight_valid = (cyc < 3);
            hs = weight_valid && weight_ready;
            if (hs) wc++;
            pixel_valid = ($urandom_range(3) != 0);
            pixel_data  = {$urandom, $urandom, pbeat(idx, c)};
            hs = pixel_valid && pixel_ready;
            @(negedge clk);
            if (hs) begin idx++; pc++; end
            cyc++; guard++;
        end
        weight_valid = 1'b0;
        pixel_valid  = 1'b0;

        if (abort_at >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_job_accept", job_accept, 0);
            check("rst_weight_ready", weight_ready, 0);
            check("rst_pixel_ready", pixel_ready, 0);
            check("rst_result_valid", result_valid, 0);
            check("rst_job_complete", job_complete, 0);
            check("rst_result_data", result_data, 0);
            rst = 1'b0;
            @(negedge clk);
            check("job_accept_after_rst", job_accept, 1);
            return;
        end

        // Extra beats offered after each phase must not be taken
        for (int i = 0; i < 3; i++) begin
            weight_valid = 1'b1;
            pixel_valid  = 1'b1;
            if (weight_ready) wc++;
            if (pixel_ready) pc++;
            @(negedge clk);
        end
        weight_valid = 1'b0;
        pixel_valid  = 1'b0;
        check("weight_beats", wc, k*9);
        check("pixel_beats", pc, (k > 0) ? r*c : 0);

        budget = 60 * (k * ((r << u) + 2) * ((c << u) + 2)) + 200;
        guard = 0;
        while (!job_complete && guard < budget) begin @(negedge clk); guard++; end
        check("job_complete", job_complete, 1);
        check("results_outstanding", exp_q.size(), 0);
        exp_q.delete();
        job_complete_ack = 1'b1;
        @(negedge clk);
        job_complete_ack = 1'b0;
        check("job_complete_cleared", job_complete, 0);
        check("job_accept_after_ack", job_accept, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, k, s, p, u;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_job_accept", job_accept, 0);
        check("reset_result_valid", result_valid, 0);
        check("reset_job_complete", job_complete, 0);
        check("reset_ready", {weight_ready, pixel_ready}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("job_accept_rise", job_accept, 1);

        fill(1, 1);
        run_job(5, 5, 1, 1, 0, 0, -1);   // basic: 9 x 36
        run_job(5, 5, 1, 1, 1, 0, -1);   // padding: 16/24/36
        run_job(5, 5, 1, 2, 0, 0, -1);   // stride 2: 4 x 36

        fill(0, 0);
        wts[0][4][0] = 16'sd1;
        pix[0][0][0] = 16'sd1; pix[0][1][0] = 16'sd2;
        pix[1][0][0] = 16'sd3; pix[1][1][0] = 16'sd4;
        run_job(2, 2, 1, 1, 1, 1, -1);   // upsample

        fill(1, 1);
        for (int t = 0; t < 9; t++) for (int ch = 0; ch < 4; ch++) wts[1][t][ch] = 16'sd2;
        stall_req = 10;
        run_job(5, 5, 2, 1, 0, 0, -1);   // 36,72,... with stall

        run_job(5, 5, 0, 1, 0, 0, -1);   // K=0
        run_job(1, 2, 1, 1, 0, 0, -1);   // no outputs
        run_job(5, 5, 1, 1, 0, 0, 7);    // reset mid LOAD_P
        run_job(5, 5, 1, 1, 0, 0, -1);   // fresh job after reset

        fill(16'h7FFF, 2);
        run_job(3, 3, 1, 1, 0, 0, -1);   // wrap to 0xFFB8

        for (int j = 0; j < 6; j++) begin
            fill_random();
            r = $urandom_range(1, 4);
            c = $urandom_range(1, 4);
            k = $urandom_range(1, 2);
            s = $urandom_range(1, 2);
            p = $urandom_range(0, 1);
            u = $urandom_range(0, 1);
            run_job(r, c, k, s, p, u, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
